// File: rtl/codec_buffer_nd_wctrl_pkg.sv
`default_nettype none
// ---- codec_buffer_nD_pkg : write-sequencer state type and address-width helper ----
// ---- rev 1.0                                                                     ----
package codec_buffer_nD_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wctrl_state_t;

  function automatic int waddr_width(input int bnum_w, input int addr_w);
    return bnum_w + addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/codec_buffer_nd_wctrl.sv
`default_nettype none
// ---- codec_buffer_nd_wctrl : write-side frame sequencer for the multi-bank codec buffer ----
// ---- rev 1.0                                                                              ----
module codec_buffer_nd_wctrl
  import codec_buffer_nD_pkg::*;
#(
  parameter int pBNUM_W = 1,
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 8
) (
  input  logic                                        iclk,
  input  logic                                        ireset,
  input  logic                                        isop,
  input  logic                                        ieop,
  input  logic                                        ival,
  input  logic [pDAT_W-1:0]                           idat,
  input  logic [pADDR_W-1:0]                          ilen,
  output logic                                        ordy,
  input  logic [pBNUM_W-1:0]                          ib_wused,
  input  logic                                        ib_wfulla,
  output logic                                        owrite,
  output logic [waddr_width(pBNUM_W, pADDR_W)-1:0]    owaddr,
  output logic [pDAT_W-1:0]                           owdat,
  output logic                                        owfull,
  output logic                                        oerr_sop,
  output logic                                        oerr_len
);

  localparam int c_AW = waddr_width(pBNUM_W, pADDR_W);

  wctrl_state_t         r_state;
  wctrl_state_t         w_state_nxt;
  logic [pBNUM_W-1:0]   r_bank;
  logic [pBNUM_W-1:0]   w_bank_nxt;
  logic [pADDR_W-1:0]   r_len;
  logic [pADDR_W-1:0]   w_len_nxt;
  logic [pADDR_W-1:0]   r_cnt;
  logic [pADDR_W-1:0]   w_cnt_nxt;

  logic                 w_accept;
  logic                 w_start;
  logic                 w_cont;
  logic                 w_len_hit;
  logic                 w_close;
  logic                 w_write;
  logic [pADDR_W-1:0]   w_word;
  logic [pBNUM_W-1:0]   w_bank_eff;
  logic [c_AW-1:0]      w_waddr;
  logic                 w_full;
  logic                 w_err_sop;
  logic                 w_err_len;

  assign ordy     = ((r_state == IDLE) && !ib_wfulla) || (r_state == WRITE);
  assign w_accept = ival && ordy;

  // A sop restarts the frame from either IDLE or WRITE; plain words only count inside a frame.
  assign w_start   = w_accept && isop;
  assign w_cont    = w_accept && !isop && (r_state == WRITE);
  assign w_len_hit = w_start ? (ilen == '0) : (r_cnt == r_len);
  assign w_close   = (w_start || w_cont) && (w_len_hit || ieop);

  // An aborted frame keeps its latched bank; only a fresh frame picks up ib_wused.
  assign w_bank_eff = (r_state == IDLE) ? ib_wused : r_bank;
  assign w_word     = w_start ? '0 : r_cnt;
  assign w_waddr    = {w_bank_eff, w_word};

  always_comb begin
    w_state_nxt = r_state;
    w_bank_nxt  = r_bank;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_write     = 1'b0;
    w_full      = 1'b0;
    w_err_sop   = 1'b0;
    w_err_len   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = w_close ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (w_start || w_cont) begin
          w_state_nxt = w_close ? DONE : WRITE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_start || w_cont) begin
      w_write   = 1'b1;
      w_full    = w_close;
      w_err_len = w_close && (w_len_hit != ieop);
      w_bank_nxt = w_bank_eff;
    end
    if (w_start) begin
      w_len_nxt = ilen;
      w_cnt_nxt = pADDR_W'(1);
      w_err_sop = (r_state == WRITE);
    end else if (w_cont) begin
      w_cnt_nxt = r_cnt + pADDR_W'(1);
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_bank   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      owrite   <= 1'b0;
      owaddr   <= '0;
      owdat    <= '0;
      owfull   <= 1'b0;
      oerr_sop <= 1'b0;
      oerr_len <= 1'b0;
    end else begin
      r_bank   <= w_bank_nxt;
      r_len    <= w_len_nxt;
      r_cnt    <= w_cnt_nxt;
      owrite   <= w_write;
      owfull   <= w_full;
      oerr_sop <= w_err_sop;
      oerr_len <= w_err_len;
      if (w_write) begin
        owaddr <= w_waddr;
        owdat  <= idat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_codec_buffer_nd_wctrl.sv
`default_nettype none
// ---- tb_codec_buffer_nd_wctrl : directed and randomized checks of the write sequencer ----
// ---- rev 1.0                                                                            ----
module tb_codec_buffer_nd_wctrl;

  localparam int NB = 2;

  logic       iclk = 1'b0;
  logic       ireset = 1'b1;
  logic       isop = 1'b0;
  logic       ieop = 1'b0;
  logic       ival = 1'b0;
  logic [7:0] idat = 8'h00;
  logic [3:0] ilen = 4'h0;
  logic       ordy;
  logic [0:0] ib_wused = 1'b0;
  logic       ib_wfulla = 1'b0;
  logic       owrite;
  logic [4:0] owaddr;
  logic [7:0] owdat;
  logic       owfull;
  logic       oerr_sop;
  logic       oerr_len;

  codec_buffer_nd_wctrl #(.pBNUM_W(1), .pADDR_W(4), .pDAT_W(8)) dut (
    .iclk(iclk), .ireset(ireset), .isop(isop), .ieop(ieop), .ival(ival),
    .idat(idat), .ilen(ilen), .ordy(ordy), .ib_wused(ib_wused),
    .ib_wfulla(ib_wfulla), .owrite(owrite), .owaddr(owaddr), .owdat(owdat),
    .owfull(owfull), .oerr_sop(oerr_sop), .oerr_len(oerr_len)
  );

  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;

  // frame-level reference: in a frame or not, index of next word, one gap cycle after close
  bit         m_busy = 0;
  bit         m_done = 0;
  int         m_bank = 0;
  int         m_len = 0;
  int         m_idx = 0;
  bit         exp_rdy, exp_write, exp_full, exp_esop, exp_elen;
  logic [4:0] exp_addr = 5'h00;
  logic [7:0] exp_dat = 8'h00;
  bit         act_rdy;

  // bank logic stand-in: number of occupied banks and current write bank
  int         bk_wused = 0;
  int         bk_occ = 0;
  bit         prev_full = 0;

  task automatic cyc(input bit r, input bit s, input bit e, input bit v,
                     input logic [7:0] d, input logic [3:0] l);
    bit by_len;
    bit close;
    @(negedge iclk);
    ireset = r; isop = s; ieop = e; ival = v; idat = d; ilen = l;
    ib_wused  = bk_wused[0];
    ib_wfulla = (bk_occ == NB);
    #1 act_rdy = ordy;
    exp_rdy   = !m_done && (m_busy || (bk_occ != NB));
    exp_write = 0; exp_full = 0; exp_esop = 0; exp_elen = 0;
    if (r) begin
      m_busy = 0; m_done = 0; exp_addr = 5'h00; exp_dat = 8'h00;
    end else if (m_done) begin
      m_done = 0;
    end else if (v && exp_rdy && (s || m_busy)) begin
      if (s) begin
        exp_esop = m_busy;
        if (!m_busy) m_bank = bk_wused;
        m_len = int'(l);
        m_idx = 0;
      end
      exp_write = 1;
      exp_addr  = 5'(m_bank * 16 + m_idx);
      exp_dat   = d;
      by_len    = (m_idx == m_len);
      close     = by_len || e;
      exp_full  = close;
      exp_elen  = (by_len != e);
      if (close) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_busy = 1; m_idx++;
      end
    end
    @(posedge iclk);
    #1;
    if (prev_full) begin
      bk_wused = (bk_wused + 1) % NB;
      bk_occ++;
    end
    prev_full = exp_full;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 8'h00, 4'h0);
    cyc(1, 0, 0, 0, 8'h00, 4'h0);
    checks++;
    if ({owrite, owfull, oerr_sop, oerr_len} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b need 0000", {owrite, owfull, oerr_sop, oerr_len});
    end
    checks++;
    if (owaddr !== 5'h00 || owdat !== 8'h00) begin
      errors++; $display("FAIL reset_bus: got addr=%h dat=%h need 0", owaddr, owdat);
    end
    cyc(0, 0, 0, 0, 8'h00, 4'h0);
    checks++;
    if (act_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy: got %b need 1", act_rdy);
    end
  endtask

  task automatic test_basic_frame();
    bk_occ = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, i == 0, i == 3, 1, 8'hA0 + 8'(i), 4'd3);
      checks++;
      if (owrite !== 1'b1 || owaddr !== 5'(i) || owdat !== 8'hA0 + 8'(i) || owfull !== (i == 3)
          || oerr_len !== 1'b0 || oerr_sop !== 1'b0) begin
        errors++;
        $display("FAIL basic_word%0d: got wr=%b addr=%h dat=%h full=%b el=%b es=%b need addr=%h full=%b",
                 i, owrite, owaddr, owdat, owfull, oerr_len, oerr_sop, 5'(i), (i == 3));
      end
    end
    cyc(0, 1, 1, 1, 8'h11, 4'd0);
    checks++;
    if (act_rdy !== 1'b0 || owrite !== 1'b0 || owfull !== 1'b0) begin
      errors++; $display("FAIL basic_done: got rdy=%b wr=%b full=%b need 0 0 0", act_rdy, owrite, owfull);
    end
    cyc(0, 1, 1, 1, 8'h55, 4'd0);
    checks++;
    if (owrite !== 1'b1 || owaddr !== 5'h10 || owfull !== 1'b1) begin
      errors++; $display("FAIL basic_next_bank: got wr=%b addr=%h full=%b need 1 10 1", owrite, owaddr, owfull);
    end
    cyc(0, 0, 0, 0, 8'h00, 4'd0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 1, 8'h77, 4'd0);
      checks++;
      if (act_rdy !== 1'b0 || owrite !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got rdy=%b wr=%b need 0 0", i, act_rdy, owrite);
      end
    end
    bk_occ = 1;
    cyc(0, 1, 1, 1, 8'h78, 4'd0);
    checks++;
    if (act_rdy !== 1'b1 || owrite !== 1'b1 || owaddr !== 5'h00 || owdat !== 8'h78) begin
      errors++; $display("FAIL bp_release: got rdy=%b wr=%b addr=%h dat=%h need 1 1 00 78",
                         act_rdy, owrite, owaddr, owdat);
    end
    cyc(0, 0, 0, 0, 8'h00, 4'd0);
    bk_occ = 0;
  endtask

  task automatic test_single_word();
    cyc(0, 1, 1, 1, 8'h3C, 4'd0);
    checks++;
    if (owrite !== 1'b1 || owaddr !== 5'h10 || owfull !== 1'b1 || oerr_len !== 1'b0 || oerr_sop !== 1'b0) begin
      errors++; $display("FAIL single: got wr=%b addr=%h full=%b el=%b es=%b need 1 10 1 0 0",
                         owrite, owaddr, owfull, oerr_len, oerr_sop);
    end
    cyc(0, 0, 0, 0, 8'h00, 4'd0);
    checks++;
    if (owfull !== 1'b0 || owrite !== 1'b0) begin
      errors++; $display("FAIL single_pulse: got full=%b wr=%b need 0 0", owfull, owrite);
    end
    bk_occ = 0;
  endtask

  task automatic test_len_err();
    for (int i = 0; i < 3; i++) begin
      cyc(0, i == 0, i == 2, 1, 8'(i), 4'd5);
      checks++;
      if (owfull !== (i == 2) || oerr_len !== (i == 2) || owaddr !== 5'(i)) begin
        errors++; $display("FAIL early_eop%0d: got full=%b el=%b addr=%h need %b %b %h",
                           i, owfull, oerr_len, owaddr, (i == 2), (i == 2), 5'(i));
      end
    end
    cyc(0, 0, 0, 0, 8'h00, 4'd0);
    bk_occ = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, i == 0, 0, 1, 8'(i), 4'd2);
      checks++;
      if (owfull !== (i == 2) || oerr_len !== (i == 2) || owaddr !== 5'(16 + i)) begin
        errors++; $display("FAIL missing_eop%0d: got full=%b el=%b addr=%h need %b %b %h",
                           i, owfull, oerr_len, owaddr, (i == 2), (i == 2), 5'(16 + i));
      end
    end
    cyc(0, 0, 0, 0, 8'h00, 4'd0);
    bk_occ = 0;
  endtask

  task automatic test_sop_abort();
    int b;
    b = bk_wused;
    cyc(0, 1, 0, 1, 8'hC0, 4'd3);
    cyc(0, 1, 0, 1, 8'hC1, 4'd3);
    checks++;
    if (oerr_sop !== 1'b1 || owfull !== 1'b0 || owaddr !== 5'(b * 16)) begin
      errors++; $display("FAIL abort_sop: got es=%b full=%b addr=%h need 1 0 %h", oerr_sop, owfull, owaddr, 5'(b * 16));
    end
    cyc(0, 0, 0, 1, 8'hC2, 4'd0);
    cyc(0, 0, 0, 1, 8'hC3, 4'd0);
    cyc(0, 0, 1, 1, 8'hC4, 4'd0);
    checks++;
    if (owfull !== 1'b1 || oerr_len !== 1'b0 || oerr_sop !== 1'b0 || owaddr !== 5'(b * 16 + 3)) begin
      errors++; $display("FAIL abort_close: got full=%b el=%b es=%b addr=%h need 1 0 0 %h",
                         owfull, oerr_len, oerr_sop, owaddr, 5'(b * 16 + 3));
    end
    cyc(0, 0, 0, 0, 8'h00, 4'd0);
    bk_occ = 0;
  endtask

  task automatic test_reset_mid();
    int b;
    b = bk_wused;
    cyc(0, 1, 0, 1, 8'hE0, 4'd3);
    cyc(1, 0, 0, 1, 8'hE1, 4'd3);
    checks++;
    if ({owrite, owfull, oerr_sop, oerr_len} !== 4'b0000 || owaddr !== 5'h00 || owdat !== 8'h00) begin
      errors++; $display("FAIL midreset_out: got flags=%b addr=%h dat=%h need all 0",
                         {owrite, owfull, oerr_sop, oerr_len}, owaddr, owdat);
    end
    cyc(0, 1, 1, 1, 8'hE2, 4'd0);
    checks++;
    if (act_rdy !== 1'b1 || owrite !== 1'b1 || owaddr !== 5'(b * 16)) begin
      errors++; $display("FAIL midreset_next: got rdy=%b wr=%b addr=%h need 1 1 %h", act_rdy, owrite, owaddr, 5'(b * 16));
    end
    cyc(0, 0, 0, 0, 8'h00, 4'd0);
    bk_occ = 0;
  endtask

  task automatic test_random();
    bit s, e, v, r;
    for (int n = 0; n < 600; n++) begin
      if (bk_occ > 0 && $urandom_range(0, 5) == 0) bk_occ--;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 4) == 0);
      v = ($urandom_range(0, 3) != 0);
      cyc(r, s, e, v, 8'($urandom), 4'($urandom_range(0, 5)));
      checks++;
      if (act_rdy !== exp_rdy) begin
        errors++; $display("FAIL rand_rdy@%0d: got %b need %b", n, act_rdy, exp_rdy);
      end
      checks++;
      if ({owrite, owfull, oerr_sop, oerr_len} !== {exp_write, exp_full, exp_esop, exp_elen}) begin
        errors++; $display("FAIL rand_flags@%0d: got %b need %b", n,
                           {owrite, owfull, oerr_sop, oerr_len}, {exp_write, exp_full, exp_esop, exp_elen});
      end
      if (exp_write) begin
        checks++;
        if (owaddr !== exp_addr || owdat !== exp_dat) begin
          errors++; $display("FAIL rand_data@%0d: got addr=%h dat=%h need %h %h", n, owaddr, owdat, exp_addr, exp_dat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_single_word();
    test_len_err();
    test_sop_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
